// File: rtl/uart_cmd_scheduler.sv
// uart_cmd_scheduler: arbitrates pending FREQ / PERIOD / channel entries and
// issues their command frames byte by byte over a UART start/done handshake.
// Ports: clk_i, rst_i (sync, active high); ch_wr_i/ch_sel_i/ch_pattern_i/
// ch_mode_i/ch_en_i, freq_wr_i/freq_pattern_i, period_wr_i/slow_period_i/
// fast_period_i entry writes; tx_start_o/tx_data_o/tx_done_i UART side;
// busy_o, frame_done_o, pending_o (per-channel pending flags) status.
`ifndef CMD_FREQ
`define CMD_FREQ 8'h01
`endif
`ifndef CMD_PERIOD
`define CMD_PERIOD 8'h02
`endif
`ifndef CMD_DATA
`define CMD_DATA 8'h03
`endif
`ifndef CMD_CTRL
`define CMD_CTRL 8'h04
`endif

module uart_cmd_scheduler #(
  parameter int unsigned OUTPUT_NUM = 16,
  parameter logic [7:0]  CMD_FREQ   = `CMD_FREQ,
  parameter logic [7:0]  CMD_PERIOD = `CMD_PERIOD,
  parameter logic [7:0]  CMD_DATA   = `CMD_DATA,
  parameter logic [7:0]  CMD_CTRL   = `CMD_CTRL,
  localparam int unsigned CW =
    (OUTPUT_NUM > 1) ? $clog2(OUTPUT_NUM) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ch_wr_i,
  input  logic [CW-1:0]         ch_sel_i,
  input  logic [31:0]           ch_pattern_i,
  input  logic [1:0]            ch_mode_i,
  input  logic                  ch_en_i,
  input  logic                  freq_wr_i,
  input  logic [31:0]           freq_pattern_i,
  input  logic                  period_wr_i,
  input  logic [7:0]            slow_period_i,
  input  logic [7:0]            fast_period_i,
  output logic                  tx_start_o,
  output logic [7:0]            tx_data_o,
  input  logic                  tx_done_i,
  output logic                  busy_o,
  output logic                  frame_done_o,
  output logic [OUTPUT_NUM-1:0] pending_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_SEND,
    S_WAIT
  } state_e;

  state_e state_q, state_d;

  logic [31:0] ch_pat_q  [OUTPUT_NUM];
  logic [1:0]  ch_mode_q [OUTPUT_NUM];
  logic [OUTPUT_NUM-1:0] ch_en_q;
  logic [OUTPUT_NUM-1:0] ch_pend_q, ch_pend_d;
  logic [OUTPUT_NUM-1:0] ch_set, ch_clr;

  logic [31:0] freq_pat_q;
  logic        freq_pend_q, freq_pend_d;
  logic [7:0]  slow_q, fast_q;
  logic        per_pend_q, per_pend_d;

  logic [CW-1:0] rr_q, rr_d;

  logic [7:0] frm_q [0:8];
  logic [7:0] frm_d [0:8];
  logic [3:0] last_q, last_d;
  logic [3:0] idx_q, idx_d;
  logic       done_q, done_d;

  logic          is_grant;
  logic          g_ch;
  logic [CW-1:0] g_idx;
  logic          any_grant;
  logic          any_wr;
  logic [7:0]    gfr [0:8];
  logic [3:0]    glast;
  logic [31:0]   gpat;
  logic [7:0]    gch;
  int            k;

  // Round-robin search over channel flags, starting at rr_q.
  always_comb begin
    g_ch  = 1'b0;
    g_idx = '0;
    k     = 0;
    for (int i = 0; i < int'(OUTPUT_NUM); i++) begin
      k = (int'(rr_q) + i) % int'(OUTPUT_NUM);
      if (!g_ch && ch_pend_q[CW'(k)]) begin
        g_ch  = 1'b1;
        g_idx = CW'(k);
      end
    end
  end

  assign any_grant = freq_pend_q | per_pend_q | g_ch;
  assign any_wr    = ch_wr_i | freq_wr_i | period_wr_i;
  assign is_grant  = (state_q == S_GRANT);

  // Frame image for whichever entry wins the fixed-priority pick.
  always_comb begin
    for (int i = 0; i < 9; i++) gfr[i] = 8'h00;
    glast = 4'd0;
    gpat  = ch_pat_q[g_idx];
    gch   = 8'(g_idx);
    if (freq_pend_q) begin
      gfr[0] = CMD_FREQ;
      gfr[1] = freq_pat_q[7:0];
      gfr[2] = freq_pat_q[15:8];
      gfr[3] = freq_pat_q[23:16];
      gfr[4] = freq_pat_q[31:24];
      glast  = 4'd4;
    end else if (per_pend_q) begin
      gfr[0] = CMD_PERIOD;
      gfr[1] = slow_q;
      gfr[2] = fast_q;
      glast  = 4'd2;
    end else begin
      gfr[0] = CMD_DATA;
      gfr[1] = gch;
      gfr[2] = gpat[7:0];
      gfr[3] = gpat[15:8];
      gfr[4] = gpat[23:16];
      gfr[5] = gpat[31:24];
      gfr[6] = CMD_CTRL;
      gfr[7] = gch;
      gfr[8] = {5'b0, ch_mode_q[g_idx], ch_en_q[g_idx]};
      glast  = 4'd8;
    end
  end

  // A write landing in the grant cycle re-sets the flag it clears.
  always_comb begin
    ch_set = '0;
    ch_clr = '0;
    if (ch_wr_i) ch_set[ch_sel_i] = 1'b1;
    if (is_grant && !freq_pend_q && !per_pend_q && g_ch)
      ch_clr[g_idx] = 1'b1;
    ch_pend_d   = (ch_pend_q & ~ch_clr) | ch_set;
    freq_pend_d = (freq_pend_q & ~is_grant) | freq_wr_i;
    per_pend_d  = (per_pend_q &
                   ~(is_grant & ~freq_pend_q)) | period_wr_i;
    rr_d = rr_q;
    if (ch_clr != '0)
      rr_d = (g_idx == CW'(OUTPUT_NUM - 1)) ? '0 : g_idx + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    done_d  = 1'b0;
    for (int i = 0; i < 9; i++) frm_d[i] = frm_q[i];
    unique case (state_q)
      S_IDLE: begin
        if (any_grant || any_wr) state_d = S_GRANT;
      end
      S_GRANT: begin
        for (int i = 0; i < 9; i++) frm_d[i] = gfr[i];
        last_d  = glast;
        idx_d   = 4'd0;
        state_d = any_grant ? S_SEND : S_IDLE;
      end
      S_SEND: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (tx_done_i) begin
          if (idx_q == last_q) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = S_SEND;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      ch_pend_q   <= '0;
      ch_en_q     <= '0;
      freq_pat_q  <= '0;
      freq_pend_q <= 1'b0;
      slow_q      <= '0;
      fast_q      <= '0;
      per_pend_q  <= 1'b0;
      rr_q        <= '0;
      last_q      <= '0;
      idx_q       <= '0;
      done_q      <= 1'b0;
      for (int i = 0; i < int'(OUTPUT_NUM); i++) begin
        ch_pat_q[i]  <= '0;
        ch_mode_q[i] <= '0;
      end
      for (int i = 0; i < 9; i++) frm_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      ch_pend_q   <= ch_pend_d;
      freq_pend_q <= freq_pend_d;
      per_pend_q  <= per_pend_d;
      rr_q        <= rr_d;
      last_q      <= last_d;
      idx_q       <= idx_d;
      done_q      <= done_d;
      for (int i = 0; i < 9; i++) frm_q[i] <= frm_d[i];
      if (ch_wr_i) begin
        ch_pat_q[ch_sel_i]  <= ch_pattern_i;
        ch_mode_q[ch_sel_i] <= ch_mode_i;
        ch_en_q[ch_sel_i]   <= ch_en_i;
      end
      if (freq_wr_i) freq_pat_q <= freq_pattern_i;
      if (period_wr_i) begin
        slow_q <= slow_period_i;
        fast_q <= fast_period_i;
      end
    end
  end

  assign tx_start_o   = (state_q == S_SEND);
  assign tx_data_o    = (state_q == S_SEND || state_q == S_WAIT)
                        ? frm_q[idx_q] : 8'h00;
  assign busy_o       = (state_q != S_IDLE);
  assign frame_done_o = done_q;
  assign pending_o    = ch_pend_q;

endmodule

// File: tb/tb_uart_cmd_scheduler.sv
// tb_uart_cmd_scheduler: scoreboard bench for uart_cmd_scheduler with a
// UART model answering each start with a done pulse 10 cycles later.
module tb_uart_cmd_scheduler;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        ch_wr_i;
  logic [3:0]  ch_sel_i;
  logic [31:0] ch_pattern_i;
  logic [1:0]  ch_mode_i;
  logic        ch_en_i;
  logic        freq_wr_i;
  logic [31:0] freq_pattern_i;
  logic        period_wr_i;
  logic [7:0]  slow_period_i;
  logic [7:0]  fast_period_i;
  logic        tx_start_o;
  logic [7:0]  tx_data_o;
  logic        tx_done_i;
  logic        busy_o;
  logic        frame_done_o;
  logic [15:0] pending_o;

  uart_cmd_scheduler #(.OUTPUT_NUM(16)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .ch_wr_i(ch_wr_i), .ch_sel_i(ch_sel_i),
    .ch_pattern_i(ch_pattern_i), .ch_mode_i(ch_mode_i),
    .ch_en_i(ch_en_i),
    .freq_wr_i(freq_wr_i), .freq_pattern_i(freq_pattern_i),
    .period_wr_i(period_wr_i), .slow_period_i(slow_period_i),
    .fast_period_i(fast_period_i),
    .tx_start_o(tx_start_o), .tx_data_o(tx_data_o),
    .tx_done_i(tx_done_i), .busy_o(busy_o),
    .frame_done_o(frame_done_o), .pending_o(pending_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] exp_q[$];
  int         len_q[$];
  int checks = 0;
  int failures = 0;
  int nbytes = 0;
  int nstarts = 0;
  int last_done_cyc = -100;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic push_freq(input logic [31:0] p);
    exp_q.push_back(8'h01);
    exp_q.push_back(p[7:0]);
    exp_q.push_back(p[15:8]);
    exp_q.push_back(p[23:16]);
    exp_q.push_back(p[31:24]);
    len_q.push_back(5);
  endtask

  task automatic push_per(input logic [7:0] s, input logic [7:0] f);
    exp_q.push_back(8'h02);
    exp_q.push_back(s);
    exp_q.push_back(f);
    len_q.push_back(3);
  endtask

  task automatic push_ch(input logic [3:0] ch, input logic [31:0] p,
                         input logic [1:0] m, input logic e);
    exp_q.push_back(8'h03);
    exp_q.push_back({4'h0, ch});
    exp_q.push_back(p[7:0]);
    exp_q.push_back(p[15:8]);
    exp_q.push_back(p[23:16]);
    exp_q.push_back(p[31:24]);
    exp_q.push_back(8'h04);
    exp_q.push_back({4'h0, ch});
    exp_q.push_back({5'b0, m, e});
    len_q.push_back(9);
  endtask

  task automatic wr_ch(input logic [3:0] ch, input logic [31:0] p,
                       input logic [1:0] m, input logic e);
    @(negedge clk);
    ch_wr_i = 1'b1; ch_sel_i = ch; ch_pattern_i = p;
    ch_mode_i = m; ch_en_i = e;
    @(negedge clk);
    ch_wr_i = 1'b0;
  endtask

  task automatic wr_freq(input logic [31:0] p);
    @(negedge clk);
    freq_wr_i = 1'b1; freq_pattern_i = p;
    @(negedge clk);
    freq_wr_i = 1'b0;
  endtask

  task automatic wait_quiet();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(exp_q.size() == 0 && !busy_o && pending_o == 16'h0)
               && k < 3000);
    if (k >= 3000) begin
      checks++; failures++;
      $display("FAIL quiet_timeout left=%0d busy=%0b", exp_q.size(),
               busy_o);
    end
    @(negedge clk);
  endtask

  // UART model: done pulse in the 10th cycle after each start.
  initial begin
    logic [7:0] sent;
    tx_done_i = 1'b0;
    forever begin
      @(negedge clk);
      tx_done_i = 1'b0;
      if (tx_start_o) begin
        sent = tx_data_o;
        repeat (10) @(negedge clk);
        if (busy_o) chk("tx_hold", tx_data_o, sent);
        tx_done_i = 1'b1;
        last_done_cyc = cyc;
      end
    end
  end

  // Monitor: compares every issued byte and every frame completion.
  always @(negedge clk) begin
    if (tx_start_o) begin
      nstarts++;
      if (nbytes > 0) chk("byte_gap", cyc, last_done_cyc + 1);
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_start actual=%02h expected=none",
                 tx_data_o);
      end else begin
        chk("tx_byte", tx_data_o, exp_q.pop_front());
      end
      nbytes++;
    end
    if (frame_done_o) begin
      chk("frame_done_timing", cyc, last_done_cyc + 1);
      if (len_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_frame_done actual=1 expected=0");
      end else begin
        chk("frame_len", nbytes, len_q.pop_front());
      end
      nbytes = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int k;
    int s0;
    rst_i = 1'b1; ch_wr_i = 1'b0; ch_sel_i = '0; ch_pattern_i = '0;
    ch_mode_i = '0; ch_en_i = 1'b0; freq_wr_i = 1'b0;
    freq_pattern_i = '0; period_wr_i = 1'b0;
    slow_period_i = '0; fast_period_i = '0;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    chk("rst_tx_start", tx_start_o, 0);
    chk("rst_tx_data", tx_data_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_frame_done", frame_done_o, 0);
    chk("rst_pending", pending_o, 16'h0000);

    // FREQ frame with start latency check.
    @(negedge clk);
    freq_wr_i = 1'b1; freq_pattern_i = 32'h5555_5555;
    c0 = cyc;
    push_freq(32'h5555_5555);
    @(negedge clk);
    freq_wr_i = 1'b0;
    chk("grant_busy", busy_o, 1);
    k = 0;
    while (!tx_start_o && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("start_latency", cyc, c0 + 2);
    // Round-robin from rr_ptr=0 while the FREQ frame is in flight.
    push_ch(4'd0, 32'hA0A1_A2A3, 2'b00, 1'b1);
    push_ch(4'd7, 32'h7777_0007, 2'b10, 1'b0);
    push_ch(4'd15, 32'hF0F1_F2F3, 2'b01, 1'b1);
    wr_ch(4'd15, 32'hF0F1_F2F3, 2'b01, 1'b1);
    wr_ch(4'd0, 32'hA0A1_A2A3, 2'b00, 1'b1);
    wr_ch(4'd7, 32'h7777_0007, 2'b10, 1'b0);
    chk("rr_pending", pending_o, 16'h8081);
    wait_quiet();

    // rr_ptr=8 after channel 7: 15 is served before 0.
    push_ch(4'd7, 32'h0102_0304, 2'b01, 1'b0);
    push_ch(4'd15, 32'hDEAD_BEEF, 2'b10, 1'b1);
    push_ch(4'd0, 32'hCAFE_F00D, 2'b00, 1'b0);
    wr_ch(4'd7, 32'h0102_0304, 2'b01, 1'b0);
    wr_ch(4'd0, 32'hCAFE_F00D, 2'b00, 1'b0);
    wr_ch(4'd15, 32'hDEAD_BEEF, 2'b10, 1'b1);
    wait_quiet();

    // Priority: channel 3, period and freq in one cycle.
    push_freq(32'hA1B2_C3D4);
    push_per(8'h14, 8'h05);
    push_ch(4'd3, 32'h1122_3344, 2'b01, 1'b1);
    @(negedge clk);
    ch_wr_i = 1'b1; ch_sel_i = 4'd3; ch_pattern_i = 32'h1122_3344;
    ch_mode_i = 2'b01; ch_en_i = 1'b1;
    period_wr_i = 1'b1; slow_period_i = 8'h14; fast_period_i = 8'h05;
    freq_wr_i = 1'b1; freq_pattern_i = 32'hA1B2_C3D4;
    @(negedge clk);
    ch_wr_i = 1'b0; period_wr_i = 1'b0; freq_wr_i = 1'b0;
    chk("prio_pending", pending_o, 16'h0008);
    wait_quiet();

    // Coalescing: two writes to channel 2 while busy.
    push_freq(32'h0F0F_0F0F);
    push_ch(4'd2, 32'hBBBB_0002, 2'b10, 1'b1);
    wr_freq(32'h0F0F_0F0F);
    wr_ch(4'd2, 32'hAAAA_0001, 2'b01, 1'b0);
    wr_ch(4'd2, 32'hBBBB_0002, 2'b10, 1'b1);
    chk("coalesce_pending", pending_o, 16'h0004);
    wait_quiet();

    // Re-arm: write channel 2 again during its grant cycle.
    push_ch(4'd2, 32'h1111_2222, 2'b00, 1'b1);
    push_ch(4'd2, 32'h3333_4444, 2'b01, 1'b0);
    @(negedge clk);
    ch_wr_i = 1'b1; ch_sel_i = 4'd2; ch_pattern_i = 32'h1111_2222;
    ch_mode_i = 2'b00; ch_en_i = 1'b1;
    @(negedge clk);
    ch_pattern_i = 32'h3333_4444; ch_mode_i = 2'b01; ch_en_i = 1'b0;
    @(negedge clk);
    ch_wr_i = 1'b0;
    chk("rearm_pending", pending_o, 16'h0004);
    wait_quiet();

    // Mid-frame reset after byte 3 of a channel frame.
    push_ch(4'd5, 32'h5A5A_A5A5, 2'b01, 1'b1);
    s0 = nstarts;
    wr_ch(4'd5, 32'h5A5A_A5A5, 2'b01, 1'b1);
    wr_ch(4'd9, 32'h9999_9999, 2'b00, 1'b1);
    k = 0;
    while (nstarts - s0 < 3 && k < 200) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("reset_reached_byte3", nstarts - s0, 3);
    @(negedge clk);
    chk("pre_reset_pending", pending_o, 16'h0200);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    exp_q.delete();
    len_q.delete();
    nbytes = 0;
    chk("midrst_busy", busy_o, 0);
    chk("midrst_pending", pending_o, 16'h0000);
    chk("midrst_tx_start", tx_start_o, 0);
    chk("midrst_tx_data", tx_data_o, 0);
    s0 = nstarts;
    repeat (20) @(negedge clk);
    #1;
    chk("stray_done_no_start", nstarts - s0, 0);
    chk("post_rst_busy", busy_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
